// File: rtl/fpga_cfg_pkg.sv
// ----------------------------------------------------------------------------
// fpga_cfg_pkg : shared constants, FSM states and helpers for the cfg loader
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package fpga_cfg_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    LOAD  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  function automatic int bytes_per_frame(input int frame_w);
    return (frame_w + 7) / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cfg_bitstream_loader_if.sv
// ----------------------------------------------------------------------------
// cfg_bitstream_loader_if : byte-wide valid/ready bitstream channel
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface cfg_bitstream_loader_if;
  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

`default_nettype wire

// File: rtl/cfg_frame_packer.sv
// ----------------------------------------------------------------------------
// cfg_frame_packer : gathers bytes little-end-first into a FRAME_W-bit frame
// Rev 1.0   (requires FRAME_W > 8)
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module cfg_frame_packer
  import fpga_cfg_pkg::*;
#(
  parameter int FRAME_W = 33
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               byte_valid,
  input  logic [7:0]         byte_in,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_last
);

  localparam int BPF       = bytes_per_frame(FRAME_W);
  localparam int CNT_W     = $clog2(BPF);
  localparam int ASM_W     = 8 * (BPF - 1);
  localparam int LAST_BITS = FRAME_W - ASM_W;

  logic [CNT_W-1:0] byte_cnt;
  logic [ASM_W-1:0] asm_q;

  assign frame_last = byte_valid && (byte_cnt == CNT_W'(BPF - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
    end else if (byte_valid) begin
      byte_cnt <= frame_last ? '0 : byte_cnt + 1'b1;
    end
  end

  // The output copy only changes on a frame's last byte, so it stays put while
  // the write strobe is high even if the next frame's first byte arrives.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame <= '0;
    end else if (frame_last) begin
      frame <= {byte_in[LAST_BITS-1:0], asm_q};
    end
  end

  generate
    if (BPF == 2) begin : g_single_byte
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          asm_q <= '0;
        end else if (clear) begin
          asm_q <= '0;
        end else if (byte_valid && !frame_last) begin
          asm_q <= byte_in;
        end
      end
    end else begin : g_shift
      // Shifting in from the top leaves byte 0 in the low bits after BPF-1 bytes.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          asm_q <= '0;
        end else if (clear) begin
          asm_q <= '0;
        end else if (byte_valid && !frame_last) begin
          asm_q <= {byte_in, asm_q[ASM_W-1:8]};
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/cfg_bitstream_loader.sv
// ----------------------------------------------------------------------------
// cfg_bitstream_loader : sync/checksum-checked bitstream to addressed frame writes
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module cfg_bitstream_loader
  import fpga_cfg_pkg::*;
#(
  parameter int FRAME_W    = 33,
  parameter int NUM_FRAMES = 20,
  parameter int ADDR_W     = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  cfg_bitstream_loader_if.slave cfg,
  output logic [FRAME_W-1:0]    frame_data,
  output logic [ADDR_W-1:0]     frame_addr,
  output logic                  frame_we,
  output logic                  busy,
  output logic                  cfg_done,
  output logic                  cfg_error
);

  state_t     state;
  state_t     state_nxt;
  logic       ready_q;
  logic [7:0] csum;
  logic       xfer;
  logic       start_ok;
  logic       load_byte;
  logic       frame_last;
  logic       last_frame;
  logic       active_nxt;

  assign cfg.cfg_ready = ready_q;
  assign xfer          = cfg.cfg_valid && ready_q;
  assign start_ok      = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign load_byte     = xfer && (state == LOAD);
  assign active_nxt    = (state_nxt == SYNC) || (state_nxt == LOAD) || (state_nxt == CHECK);

  // frame_addr lags by one frame while the previous strobe is still high.
  assign last_frame = (({1'b0, frame_addr} + {{ADDR_W{1'b0}}, frame_we})
                       == (ADDR_W + 1)'(NUM_FRAMES - 1));

  cfg_frame_packer #(
    .FRAME_W (FRAME_W)
  ) u_packer (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (start_ok),
    .byte_valid (load_byte),
    .byte_in    (cfg.cfg_data),
    .frame      (frame_data),
    .frame_last (frame_last)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE, ERR: if (start) state_nxt = SYNC;
      SYNC:            if (xfer) state_nxt = (cfg.cfg_data == SYNC_BYTE) ? LOAD : ERR;
      LOAD:            if (frame_last && last_frame) state_nxt = CHECK;
      CHECK:           if (xfer) state_nxt = (cfg.cfg_data == csum) ? DONE : ERR;
      default:         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_q    <= 1'b0;
      busy       <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_error  <= 1'b0;
      frame_we   <= 1'b0;
      csum       <= '0;
      frame_addr <= '0;
    end else begin
      ready_q   <= active_nxt;
      busy      <= active_nxt;
      cfg_done  <= (state_nxt == DONE);
      cfg_error <= (state_nxt == ERR);
      frame_we  <= frame_last;
      if (start_ok) begin
        csum       <= '0;
        frame_addr <= '0;
      end else begin
        if (load_byte) begin
          csum <= csum ^ cfg.cfg_data;
        end
        if (frame_we && (frame_addr != ADDR_W'(NUM_FRAMES - 1))) begin
          frame_addr <= frame_addr + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cfg_bitstream_loader.sv
// ----------------------------------------------------------------------------
// tb_cfg_bitstream_loader : directed self-checking bench (2-frame and 20-frame DUTs)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_cfg_bitstream_loader;

  localparam int FRAME_W = 33;
  localparam int ADDR_W  = 5;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic start   = 1'b0;
  logic start2  = 1'b0;

  always #5 clock = ~clock;

  cfg_bitstream_loader_if bus ();
  cfg_bitstream_loader_if bus2 ();

  logic [FRAME_W-1:0] frame_data, big_data;
  logic [ADDR_W-1:0]  frame_addr, big_addr;
  logic               frame_we, busy, cfg_done, cfg_error;
  logic               big_we, big_busy, big_done, big_error;

  cfg_bitstream_loader #(.FRAME_W(FRAME_W), .NUM_FRAMES(2), .ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .cfg        (bus),
    .frame_data (frame_data),
    .frame_addr (frame_addr),
    .frame_we   (frame_we),
    .busy       (busy),
    .cfg_done   (cfg_done),
    .cfg_error  (cfg_error)
  );

  cfg_bitstream_loader #(.FRAME_W(FRAME_W), .NUM_FRAMES(20), .ADDR_W(ADDR_W)) dut_big (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start2),
    .cfg        (bus2),
    .frame_data (big_data),
    .frame_addr (big_addr),
    .frame_we   (big_we),
    .busy       (big_busy),
    .cfg_done   (big_done),
    .cfg_error  (big_error)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] we_addr[$];
  logic [63:0] we_data[$];
  logic [63:0] big_we_addr[$];
  logic [63:0] big_we_data[$];
  logic [7:0]  stream[$];
  logic [FRAME_W-1:0] exp_big [20];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (frame_we === 1'b1) begin
      we_addr.push_back(64'(frame_addr));
      we_data.push_back(64'(frame_data));
    end
    if (big_we === 1'b1) begin
      big_we_addr.push_back(64'(big_addr));
      big_we_data.push_back(64'(big_data));
    end
  end

  task automatic pulse_start(input bit big);
    @(negedge clock);
    if (big) start2 = 1'b1; else start = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic send_byte(input bit big, input logic [7:0] b, input int gap);
    int t;
    for (int i = 0; i < gap; i++) @(negedge clock);
    @(negedge clock);
    if (big) begin
      bus2.cfg_data = b; bus2.cfg_valid = 1'b1;
    end else begin
      bus.cfg_data = b; bus.cfg_valid = 1'b1;
    end
    t = 0;
    while (!(big ? bus2.cfg_ready : bus.cfg_ready) && t < 16) begin
      @(negedge clock);
      t++;
    end
    if (t == 16) check("xfer_ready", 64'(big ? bus2.cfg_ready : bus.cfg_ready), 64'd1);
    @(posedge clock);
    #1;
    bus.cfg_valid  = 1'b0;
    bus2.cfg_valid = 1'b0;
  endtask

  task automatic send_all(input bit big, input int first, input int last, input int maxgap);
    for (int i = first; i <= last; i++)
      send_byte(big, stream[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
  endtask

  task automatic load_stream(input logic [7:0] chk);
    stream = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01,
               8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, chk};
  endtask

  task automatic check_two(input string tag, input logic [63:0] d0, input logic [63:0] d1);
    check({tag, "_nwe"}, 64'(we_addr.size()), 64'd2);
    if (we_addr.size() == 2) begin
      check({tag, "_a0"}, we_addr[0], 64'd0);
      check({tag, "_d0"}, we_data[0], d0);
      check({tag, "_a1"}, we_addr[1], 64'd1);
      check({tag, "_d1"}, we_data[1], d1);
    end
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] csum;
    logic [7:0] fb [5];

    bus.cfg_valid  = 1'b0;
    bus.cfg_data   = 8'h00;
    bus2.cfg_valid = 1'b0;
    bus2.cfg_data  = 8'h00;

    repeat (2) @(negedge clock);
    check("rst_ready", 64'(bus.cfg_ready), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_done",  64'(cfg_done), 64'd0);
    check("rst_err",   64'(cfg_error), 64'd0);
    check("rst_we",    64'(frame_we), 64'd0);
    check("rst_addr",  64'(frame_addr), 64'd0);
    check("rst_data",  64'(frame_data), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("idle_ready", 64'(bus.cfg_ready), 64'd0);

    // Reset in the middle of frame 1
    pulse_start(1'b0);
    load_stream(8'h01);
    send_all(1'b0, 0, 7, 0);
    check("pre_rst_data", 64'(frame_data), 64'h1_0000_0001);
    check("pre_rst_addr", 64'(frame_addr), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_data",  64'(frame_data), 64'd0);
    check("arst_addr",  64'(frame_addr), 64'd0);
    check("arst_busy",  64'(busy), 64'd0);
    check("arst_ready", 64'(bus.cfg_ready), 64'd0);
    repeat (3) @(negedge clock);
    check("arst_nwe", 64'(we_addr.size()), 64'd1);
    reset_n = 1'b1;

    // Nominal load
    we_addr.delete(); we_data.delete();
    pulse_start(1'b0);
    check("sync_busy",  64'(busy), 64'd1);
    check("sync_ready", 64'(bus.cfg_ready), 64'd1);
    send_all(1'b0, 0, 5, 0);
    @(negedge clock);
    check("nom_we0",   64'(frame_we), 64'd1);
    check("nom_addr0", 64'(frame_addr), 64'd0);
    check("nom_data0", 64'(frame_data), 64'h1_0000_0001);
    send_all(1'b0, 6, 11, 0);
    @(negedge clock);
    check("nom_done",  64'(cfg_done), 64'd1);
    check("nom_err",   64'(cfg_error), 64'd0);
    check("nom_ready", 64'(bus.cfg_ready), 64'd0);
    check("nom_busy",  64'(busy), 64'd0);
    check("nom_addr",  64'(frame_addr), 64'd1);
    check_two("nom", 64'h1_0000_0001, 64'h1_FFFF_FFFF);

    // Bad sync byte
    we_addr.delete(); we_data.delete();
    pulse_start(1'b0);
    check("start_clr_done", 64'(cfg_done), 64'd0);
    send_byte(1'b0, 8'h5A, 0);
    check("bsync_err",   64'(cfg_error), 64'd1);
    check("bsync_ready", 64'(bus.cfg_ready), 64'd0);
    check("bsync_busy",  64'(busy), 64'd0);
    @(negedge clock);
    bus.cfg_data  = 8'hA5;
    bus.cfg_valid = 1'b1;
    repeat (3) @(negedge clock);
    check("bsync_noacc", 64'(bus.cfg_ready), 64'd0);
    check("bsync_hold",  64'(cfg_error), 64'd1);
    bus.cfg_valid = 1'b0;
    check("bsync_nwe", 64'(we_addr.size()), 64'd0);

    // Bad checksum
    we_addr.delete(); we_data.delete();
    pulse_start(1'b0);
    check("start_clr_err", 64'(cfg_error), 64'd0);
    load_stream(8'h00);
    send_all(1'b0, 0, 11, 0);
    @(negedge clock);
    check("bchk_err",  64'(cfg_error), 64'd1);
    check("bchk_done", 64'(cfg_done), 64'd0);
    check_two("bchk", 64'h1_0000_0001, 64'h1_FFFF_FFFF);

    // Valid gaps plus a start pulse while busy
    we_addr.delete(); we_data.delete();
    pulse_start(1'b0);
    load_stream(8'h01);
    send_all(1'b0, 0, 6, 3);
    pulse_start(1'b0);
    check("busy_start_busy", 64'(busy), 64'd1);
    check("busy_start_addr", 64'(frame_addr), 64'd1);
    send_all(1'b0, 7, 11, 3);
    @(negedge clock);
    check("gap_done", 64'(cfg_done), 64'd1);
    check("gap_err",  64'(cfg_error), 64'd0);
    check_two("gap", 64'h1_0000_0001, 64'h1_FFFF_FFFF);

    // Reload after DONE with a new stream
    we_addr.delete(); we_data.delete();
    pulse_start(1'b0);
    check("rel_done_clr", 64'(cfg_done), 64'd0);
    check("rel_addr0",    64'(frame_addr), 64'd0);
    stream = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00,
               8'hAA, 8'h55, 8'hAA, 8'h55, 8'hFE, 8'hF6};
    send_all(1'b0, 0, 11, 0);
    @(negedge clock);
    check("rel_done", 64'(cfg_done), 64'd1);
    check_two("rel", 64'h0_7856_3412, 64'h0_55AA_55AA);

    // Full 20-frame load on the second instance
    stream.delete();
    stream.push_back(8'hA5);
    csum = 8'h00;
    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < 5; k++) begin
        b = 8'(f * 5 + k + 1);
        fb[k] = b;
        stream.push_back(b);
        csum = csum ^ b;
      end
      exp_big[f] = {fb[4][0], fb[3], fb[2], fb[1], fb[0]};
    end
    stream.push_back(csum);
    pulse_start(1'b1);
    send_all(1'b1, 0, 101, 1);
    @(negedge clock);
    check("big_done", 64'(big_done), 64'd1);
    check("big_err",  64'(big_error), 64'd0);
    check("big_addr", 64'(big_addr), 64'd19);
    check("big_nwe",  64'(big_we_addr.size()), 64'd20);
    if (big_we_addr.size() == 20) begin
      for (int f = 0; f < 20; f++) begin
        check($sformatf("big_a%0d", f), big_we_addr[f], 64'(f));
        check($sformatf("big_d%0d", f), big_we_data[f], 64'(exp_big[f]));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout got=%0d exp=0", checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
